// File: rtl/lsu_bridge_pkg.sv
// lsu_bridge_pkg: shared definitions for the load/store bridge.
//   - access size codes as carried on lsu_size
//   - bridge FSM state encoding
//   - default response timeout
//   - helper that builds the read-data mask for an access size
package lsu_bridge_pkg;

    localparam logic [1:0] LSU_SIZE_BYTE = 2'd0;
    localparam logic [1:0] LSU_SIZE_HALF = 2'd1;
    localparam logic [1:0] LSU_SIZE_WORD = 2'd2;

    localparam int LSU_TIMEOUT = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Size code 3 is treated as a full word.
    function automatic logic [31:0] lsu_size_mask(input logic [1:0] size);
        case (size)
            LSU_SIZE_BYTE: lsu_size_mask = 32'h0000_00FF;
            LSU_SIZE_HALF: lsu_size_mask = 32'h0000_FFFF;
            default:       lsu_size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_bridge_if.sv
// Bus interfaces of the load/store bridge.
//   lsu_bridge_lsu_if : CPU load/store port, four-phase level handshake.
//                       master = CPU, slave = bridge.
//   lsu_bridge_mem_if : word-wide data-memory bus, valid/ready request plus
//                       a one-cycle response pulse.
//                       master = bridge, slave = memory.
interface lsu_bridge_lsu_if;
    logic        lsu_reqValid;
    logic [31:0] lsu_addr;
    logic [1:0]  lsu_size;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_respValid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;

    modport master (
        output lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_respValid, lsu_rdata, lsu_err
    );
    modport slave (
        input  lsu_reqValid, lsu_addr, lsu_size, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_respValid, lsu_rdata, lsu_err
    );
endinterface

interface lsu_bridge_mem_if;
    logic        mem_reqValid;
    logic        mem_reqReady;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_respValid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        input  mem_reqReady, mem_respValid, mem_rdata
    );
    modport slave (
        input  mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
        output mem_reqReady, mem_respValid, mem_rdata
    );
endinterface

// File: rtl/lsu_bridge_align.sv
// lsu_align: combinational byte-lane logic for the load/store bridge.
//   req_*      : live CPU request (used at capture time)
//     lane_wdata_o  store data shifted into its byte lanes
//     lane_wstrb_o  store mask shifted into its byte lanes
//     misalign_o    half on odd address, or word not on a 4-byte boundary
//   rsp_*      : captured address/size plus the raw bus word
//     rsp_rdata_o   load data right-justified and zeroed above the access size
module lsu_align
    import lsu_bridge_pkg::*;
(
    input  logic [1:0]  req_addr_lo_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wmask_i,
    input  logic [1:0]  rsp_addr_lo_i,
    input  logic [1:0]  rsp_size_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] lane_wdata_o,
    output logic [3:0]  lane_wstrb_o,
    output logic [31:0] rsp_rdata_o,
    output logic        misalign_o
);

    always_comb begin
        // Bits pushed past bit 31 / bit 3 fall off the top.
        lane_wdata_o = req_wdata_i << {req_addr_lo_i, 3'b000};
        lane_wstrb_o = req_wmask_i << req_addr_lo_i;
        rsp_rdata_o  = (rsp_rdata_i >> {rsp_addr_lo_i, 3'b000}) & lsu_size_mask(rsp_size_i);

        case (req_size_i)
            LSU_SIZE_BYTE: misalign_o = 1'b0;
            LSU_SIZE_HALF: misalign_o = req_addr_lo_i[0];
            default:       misalign_o = |req_addr_lo_i;
        endcase
    end

endmodule

// File: rtl/lsu_bridge.sv
// lsu_bridge: CPU load/store port to word-wide data-memory bus.
//   clock, reset : system clock, synchronous active-high reset
//   lsu          : CPU side (slave modport), level handshake
//   mem          : memory side (master modport), valid/ready + response pulse
// Every output comes straight from a register. A misaligned access completes
// with err and never touches the bus; a bus access that does not finish
// within TIMEOUT busy cycles completes with err (TIMEOUT = 0 disables this).
//
//   state | meaning
//   IDLE  | waiting for lsu_reqValid, captures the request
//   REQ   | mem_reqValid high, waiting for mem_reqReady
//   WAIT  | accepted, waiting for mem_respValid
//   DONE  | lsu_respValid high until the CPU drops lsu_reqValid
module lsu_bridge
    import lsu_bridge_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT
)(
    input  logic             clock,
    input  logic             reset,
    lsu_bridge_lsu_if.slave  lsu,
    lsu_bridge_mem_if.master mem
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    lsu_state_e        state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] rsp_rdata;
    logic        misalign;
    logic        timeout_hit;

    lsu_align u_align (
        .req_addr_lo_i (lsu.lsu_addr[1:0]),
        .req_size_i    (lsu.lsu_size),
        .req_wdata_i   (lsu.lsu_wdata),
        .req_wmask_i   (lsu.lsu_wmask),
        .rsp_addr_lo_i (addr_q[1:0]),
        .rsp_size_i    (size_q),
        .rsp_rdata_i   (mem.mem_rdata),
        .lane_wdata_o  (lane_wdata),
        .lane_wstrb_o  (lane_wstrb),
        .rsp_rdata_o   (rsp_rdata),
        .misalign_o    (misalign)
    );

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        mem_req_d    = mem_req_q;

        case (state_q)
            ST_IDLE: begin
                if (lsu.lsu_reqValid) begin
                    addr_d  = lsu.lsu_addr;
                    size_d  = lsu.lsu_size;
                    wen_d   = lsu.lsu_wen;
                    wdata_d = lane_wdata;
                    wstrb_d = lsu.lsu_wen ? lane_wstrb : 4'b0000;
                    cnt_d   = '0;
                    if (misalign) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        err_d        = 1'b1;
                        rdata_d      = '0;
                    end else begin
                        state_d   = ST_REQ;
                        mem_req_d = 1'b1;
                    end
                end
            end
            ST_REQ, ST_WAIT: begin
                // A response arriving with acceptance completes the access;
                // completion on the last counted cycle wins over the timeout.
                if ((state_q == ST_WAIT || mem.mem_reqReady) && mem.mem_respValid) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    err_d        = 1'b0;
                    rdata_d      = wen_q ? 32'h0 : rsp_rdata;
                    mem_req_d    = 1'b0;
                end else if (timeout_hit) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    err_d        = 1'b1;
                    rdata_d      = '0;
                    mem_req_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == ST_REQ && mem.mem_reqReady) begin
                        state_d   = ST_WAIT;
                        mem_req_d = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (!lsu.lsu_reqValid) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            mem_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            mem_req_q    <= mem_req_d;
        end
    end

    assign lsu.lsu_respValid = resp_valid_q;
    assign lsu.lsu_rdata     = rdata_q;
    assign lsu.lsu_err       = err_q;
    assign mem.mem_reqValid  = mem_req_q;
    assign mem.mem_addr      = {addr_q[31:2], 2'b00};
    assign mem.mem_wen       = wen_q;
    assign mem.mem_wdata     = wdata_q;
    assign mem.mem_wstrb     = wstrb_q;

endmodule
